// File: rtl/conv_mac_l2.sv
// conv_mac_l2 -- layer-2 convolution engine.
// Takes one 4x4 unsigned pixel window per handshake, multiply-accumulates it
// against a stored signed 4x4 kernel (one kernel row per cycle), adds bias,
// applies ReLU, shifts right by SHIFT, saturates to 8 bits and presents one
// output pixel. Output handshakes are counted so the writer sees row ends.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-low reset
//   in_window  128-bit window; row r at [127-32r -: 32], column c byte c MSB-first
//   in_valid   window valid
//   in_ready   window accepted this cycle when in_valid & in_ready
//   w_we       load kernel and bias (honoured in IDLE only)
//   w_data     signed 8-bit weights, same layout as in_window
//   w_bias     signed 16-bit bias
//   out_data   unsigned result pixel, stable while out_valid is held
//   out_valid  result valid until out_ready
//   out_ready  downstream accepts out_data
//   row_done   pulses with the handshake of the ROW_LEN-th output of a row
module conv_mac_l2 #(
  parameter int SHIFT   = 4,
  parameter int ROW_LEN = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] in_window,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         w_we,
  input  logic [127:0] w_data,
  input  logic [15:0]  w_bias,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         row_done
);

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t             state;
  logic [127:0]       win_q;
  logic [127:0]       w_q;
  logic signed [15:0] b_q;
  logic signed [23:0] acc;
  logic [1:0]         row_idx;
  logic [3:0]         out_cnt;

  logic [7:0]         pix;
  logic signed [7:0]  wt;
  logic signed [16:0] prod;
  logic signed [23:0] row_sum;
  logic signed [23:0] biased;
  logic signed [23:0] shifted;
  logic [7:0]         sat;
  logic               hs;
  logic               cnt_last;

  assign in_ready = (state == IDLE) & ~w_we & rst;
  assign hs       = out_valid & out_ready & rst;
  assign cnt_last = (out_cnt == 4'(ROW_LEN - 1));
  assign row_done = hs & cnt_last;

  // Sum of the four products of the kernel row selected by row_idx.
  always_comb begin
    pix     = '0;
    wt      = '0;
    prod    = '0;
    row_sum = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      pix     = win_q[127 - 32*row_idx - 8*c -: 8];
      wt      = w_q[127 - 32*row_idx - 8*c -: 8];
      prod    = $signed({9'b0, pix}) * $signed({{9{wt[7]}}, wt});
      row_sum = row_sum + 24'(prod);
    end
  end

  // Bias, ReLU, shift and saturate on the finished accumulator.
  always_comb begin
    biased  = acc + 24'(b_q);
    shifted = biased >>> SHIFT;
    if (biased[23])
      sat = '0;
    else if (shifted > 24'sd255)
      sat = '1;
    else
      sat = shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      win_q     <= '0;
      w_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      row_idx   <= '0;
      out_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (w_we) begin
            w_q <= w_data;
            b_q <= w_bias;
          end else if (in_valid) begin
            win_q   <= in_window;
            acc     <= '0;
            row_idx <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          acc     <= acc + row_sum;
          row_idx <= row_idx + 2'd1;
          if (row_idx == 2'd3)
            state <= OUT;
        end
        OUT: begin
          // First OUT cycle registers the result from the completed
          // accumulator; later cycles wait for the handshake.
          if (!out_valid) begin
            out_data  <= sat;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            out_cnt   <= cnt_last ? '0 : out_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_l2.sv
// Bench for conv_mac_l2: two instances (SHIFT=0 and SHIFT=4) share stimulus.
// A transaction-level model predicts handshakes, results and row_done each
// cycle; directed tests additionally pin hand-computed results.
module tb_conv_mac_l2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] in_window = '0;
  logic         in_valid = 1'b0;
  logic         w_we = 1'b0;
  logic [127:0] w_data = '0;
  logic [15:0]  w_bias = '0;
  logic         out_ready = 1'b1;

  logic       ir0, ir4, ov0, ov4, rd0, rd4;
  logic [7:0] od0, od4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_mac_l2 #(.SHIFT(0), .ROW_LEN(10)) d0 (
    .clk(clk), .rst(rst), .in_window(in_window), .in_valid(in_valid),
    .in_ready(ir0), .w_we(w_we), .w_data(w_data), .w_bias(w_bias),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .row_done(rd0));

  conv_mac_l2 #(.SHIFT(4), .ROW_LEN(10)) d4 (
    .clk(clk), .rst(rst), .in_window(in_window), .in_valid(in_valid),
    .in_ready(ir4), .w_we(w_we), .w_data(w_data), .w_bias(w_bias),
    .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .row_done(rd4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Convolution result straight from the arithmetic definition.
  function automatic logic [7:0] conv(input logic [127:0] win, input logic [127:0] w,
                                      input logic [15:0] b, input int sh);
    int sum;
    logic [7:0] pb;
    logic [7:0] wb;
    sum = int'($signed(b));
    for (int k = 0; k < 16; k++) begin
      pb = win[127 - 8*k -: 8];
      wb = w[127 - 8*k -: 8];
      sum += int'(pb) * int'($signed(wb));
    end
    if (sum < 0) return 8'd0;
    sum = sum >>> sh;
    return (sum > 255) ? 8'hFF : sum[7:0];
  endfunction

  // Model: m_phase 0 = idle, 1..5 = busy, 6 = result presented.
  bit         chk_en = 0;
  int         m_phase = 0;
  int         m_cnt = 0;
  logic [127:0] m_w = '0;
  logic [15:0]  m_b = '0;
  logic [7:0]   m_d0 = '0, m_d4 = '0;

  always @(posedge clk) begin
    if (!rst) begin
      chk_en = 1;
      m_phase = 0; m_cnt = 0; m_w = '0; m_b = '0; m_d0 = '0; m_d4 = '0;
    end else if (m_phase == 0) begin
      if (w_we) begin
        m_w = w_data; m_b = w_bias;
      end else if (in_valid) begin
        m_d0 = conv(in_window, m_w, m_b, 0);
        m_d4 = conv(in_window, m_w, m_b, 4);
        m_phase = 1;
      end
    end else if (m_phase < 6) begin
      m_phase++;
    end else if (out_ready) begin
      m_phase = 0;
      m_cnt = (m_cnt == 9) ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready0", 32'(ir0), 32'((m_phase == 0) && !w_we && rst));
      check("in_ready4", 32'(ir4), 32'((m_phase == 0) && !w_we && rst));
      check("out_valid0", 32'(ov0), 32'(m_phase == 6));
      check("out_valid4", 32'(ov4), 32'(m_phase == 6));
      check("row_done0", 32'(rd0), 32'((m_phase == 6) && out_ready && rst && m_cnt == 9));
      check("row_done4", 32'(rd4), 32'((m_phase == 6) && out_ready && rst && m_cnt == 9));
      if (m_phase == 6) begin
        check("out_data0", 32'(od0), 32'(m_d0));
        check("out_data4", 32'(od4), 32'(m_d4));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load_kernel(input logic [127:0] w, input logic [15:0] b);
    w_we = 1'b1; w_data = w; w_bias = b;
    step();
    w_we = 1'b0;
  endtask

  // Called just after an accept edge: checks 5-cycle latency and results,
  // then lets the handshake happen if out_ready is high.
  task automatic wait_out(input string name, input logic [7:0] e0, input logic [7:0] e4);
    int n = 0;
    bit got = 0;
    while (n < 20 && !got) begin
      @(negedge clk);
      if (ov4) got = 1;
      else begin step(); n++; end
    end
    check({name, "_latency"}, 32'(n), 32'd5);
    check({name, "_d0"}, 32'(od0), 32'(e0));
    check({name, "_d4"}, 32'(od4), 32'(e4));
    if (out_ready) step();
  endtask

  task automatic send_window(input string name, input logic [127:0] win,
                             input logic [7:0] e0, input logic [7:0] e4);
    bit got = 0;
    in_window = win; in_valid = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (ir4) got = 1;
      step();
    end
    in_valid = 1'b0;
    check({name, "_accept"}, 32'(got), 32'd1);
    wait_out(name, e0, e4);
  endtask

  logic [127:0] w_mix;
  logic [127:0] win_a, win_b;

  initial begin
    int acc_cnt;
    int cyc, acc_n, hs, rdn;
    int rd_at[4];
    int acc_cyc[2];
    bit got;

    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 32'(ov4), 32'd0);
    check("reset_out_data", 32'(od4), 32'd0);
    check("reset_in_ready", 32'(ir4), 32'd1);
    step();

    // Identity kernel: only row0/col0 weight is 1.
    load_kernel(128'h01 << 120, 16'h0000);
    send_window("identity", 128'h37A1B2C3_D4E5F607_18293A4B_5C6D7E8F, 8'h37, 8'h03);

    // Saturation and ReLU.
    load_kernel({16{8'h01}}, 16'h0000);
    send_window("all_pos", {16{8'hFF}}, 8'hFF, 8'hFF);
    load_kernel({16{8'hFF}}, 16'h0000);
    send_window("all_neg", {16{8'hFF}}, 8'h00, 8'h00);
    load_kernel('0, 16'h7FFF);
    send_window("bias_max", {16{8'hFF}}, 8'hFF, 8'hFF);
    load_kernel('0, 16'hFFFB);
    send_window("bias_neg", {16{8'hFF}}, 8'h00, 8'h00);

    // Signed mix: +2/-1 alternating, pixels 10, bias 8 -> 88.
    w_mix = {8{8'h02, 8'hFF}};
    load_kernel(w_mix, 16'd8);
    send_window("signed_mix", {16{8'h0A}}, 8'h58, 8'h05);

    // Backpressure: A stalls in OUT with in_valid held high for B.
    win_a = {16{8'h0A}};
    win_b = {16{8'h14}};
    out_ready = 1'b0;
    in_window = win_a; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (ir4) got = 1;
      step();
    end
    check("bp_accept", 32'(got), 32'd1);
    in_window = win_b;
    wait_out("bp_a", 8'h58, 8'h05);
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_d0", 32'(od0), 32'h58);
      check("bp_hold_in_ready", 32'(ir4), 32'd0);
      if (ir4 && in_valid) acc_cnt++;
      step();
    end
    check("bp_no_extra_accept", 32'(acc_cnt), 32'd0);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("bp_next_accept", 32'(ir4), 32'd1);
    step();
    in_valid = 1'b0;
    wait_out("bp_b", 8'hA8, 8'h0A);

    // Simultaneous kernel load and window: load wins, window taken next cycle.
    w_we = 1'b1; w_data = {16{8'h01}}; w_bias = 16'h0000;
    in_window = {16{8'h02}}; in_valid = 1'b1;
    @(negedge clk);
    check("sim_in_ready_low", 32'(ir4), 32'd0);
    step();
    w_we = 1'b0;
    @(negedge clk);
    check("sim_in_ready_high", 32'(ir4), 32'd1);
    step();
    in_valid = 1'b0;
    wait_out("sim_new_kernel", 8'h20, 8'h02);

    // Reset in CALC cycle 2 aborts the window and clears the kernel.
    in_window = {16{8'h01}}; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(ov4), 32'd0);
    check("rst_mid_in_ready", 32'(ir4), 32'd1);
    step();
    send_window("after_rst", {16{8'h01}}, 8'h00, 8'h00);

    // Row count: handshake 1 was above; stream 29 more.
    cyc = 0; acc_n = 0; hs = 1; rdn = 0;
    rd_at = '{default: 0};
    acc_cyc = '{default: 0};
    in_window = {16{8'h05}}; in_valid = 1'b1;
    while (hs < 30 && cyc < 400) begin
      @(negedge clk);
      if (ir4 && in_valid) begin
        if (acc_n < 2) acc_cyc[acc_n] = cyc;
        acc_n++;
      end
      if (ov4 && out_ready) begin
        hs++;
        if (rd4) begin
          if (rdn < 4) rd_at[rdn] = hs;
          rdn++;
        end
      end
      step();
      cyc++;
      if (acc_n == 29) in_valid = 1'b0;
    end
    check("row_handshakes", 32'(hs), 32'd30);
    check("row_done_count", 32'(rdn), 32'd3);
    check("row_done_first", 32'(rd_at[0]), 32'd10);
    check("row_done_second", 32'(rd_at[1]), 32'd20);
    check("row_done_wrap", 32'(rd_at[2]), 32'd30);
    check("throughput", 32'(acc_cyc[1] - acc_cyc[0]), 32'd7);

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
